inner_fn_arbiter: RTL

- Round-robin arbiter/sequencer that shares one inner-function unit (`inner_fn_lat_fxd`: custom-instruction style, start/done, 32-bit float in/out) between NUM_REQ requesters.
- Each requester issues a start pulse with its operand. The operand is buffered and serviced in turn. The float result returns with a one-cycle done pulse.
- Sits between the CPU-side custom-instruction ports / DMA feeders and the single accelerator instance.

---
 rtl/inner_fn_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/inner_fn_arbiter.sv
// Round-robin sequencer sharing one start/done float unit between NUM_REQ requesters.
// Optional WAIT watchdog with quiet-NaN error response: define INNER_ARB_TIMEOUT_EN.
module inner_fn_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clock,
    input  logic                  aclr,
    input  logic                  clk_en,
    input  logic [NUM_REQ-1:0]    req_start,
    input  logic [32*NUM_REQ-1:0] req_dataa,
    output logic [NUM_REQ-1:0]    req_busy,
    output logic [NUM_REQ-1:0]    req_done,
    output logic [NUM_REQ-1:0]    req_err,
    output logic [31:0]           req_result,
    output logic                  unit_aclr,
    output logic                  unit_clk_en,
    output logic                  unit_start,
    output logic [31:0]           unit_dataa,
    input  logic [31:0]           unit_result,
    input  logic                  unit_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    if (NUM_REQ < 2 || NUM_REQ > 8 || IDX_W < 1 || (1 << IDX_W) < NUM_REQ ||
        TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("inner_fn_arbiter: unsupported parameter combination");
    end

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   pending_q, pending_d;
    logic [31:0]          hold_q [NUM_REQ];
    logic [31:0]          hold_d [NUM_REQ];
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [31:0]          dataa_q, dataa_d;
    logic [31:0]          res_q, res_d;

    logic                 grant_vld;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     next_ptr;
    logic [NUM_REQ-1:0]   capture;
    logic                 timeout;

    // Busy covers buffered work plus the in-service slot until its RESP cycle.
    always_comb begin
        req_busy = pending_q;
        if (state_q == ISSUE || state_q == WAIT) begin
            req_busy[idx_q] = 1'b1;
        end
    end

    assign capture  = req_start & ~req_busy;
    assign next_ptr = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    // Descending scan so the lowest offset from rr_ptr_q wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (pending_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

`ifdef INNER_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt_q;
    logic             err_q;

    assign timeout = (state_q == WAIT) && !unit_done &&
                     (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else if (clk_en) begin
            if (state_q == ISSUE) begin
                wd_cnt_q <= '0;
                err_q    <= 1'b0;
            end else if (state_q == WAIT) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
                err_q    <= timeout;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            rr_ptr_q  <= '0;
            dataa_q   <= '0;
            res_q     <= '0;
            // NOTE: operand buffers are cleared as well, so no pre-reset operand can reach unit_dataa.
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_q[i] <= '0;
            end
        end else if (clk_en) begin
            // NOTE: non-blocking, so every register samples pre-edge values whatever the statement order.
            state_q   <= state_d;
            pending_q <= pending_d;
            hold_q    <= hold_d;
            idx_q     <= idx_d;
            rr_ptr_q  <= rr_ptr_d;
            dataa_q   <= dataa_d;
            res_q     <= res_d;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first so no path through the case can infer a latch.
        state_d   = state_q;
        pending_d = pending_q | capture;
        hold_d    = hold_q;
        idx_d     = idx_q;
        rr_ptr_d  = rr_ptr_q;
        dataa_d   = dataa_q;
        res_d     = res_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (capture[i]) begin
                hold_d[i] = req_dataa[32*i +: 32];
            end
        end
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    idx_d                = grant_idx;
                    dataa_d              = hold_q[grant_idx];
                    pending_d[grant_idx] = 1'b0;
                    state_d              = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (unit_done) begin
                    res_d   = unit_result;
                    state_d = RESP;
                end else if (timeout) begin
                    res_d   = 32'h7fc0_0000;
                    state_d = RESP;
                end
            end
            RESP: begin
                rr_ptr_d = next_ptr;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        unit_start  = (state_q == ISSUE);
        unit_dataa  = dataa_q;
        unit_clk_en = clk_en;
        unit_aclr   = aclr;
        req_done    = '0;
        req_err     = '0;
        req_result  = '0;
        if (state_q == RESP) begin
            req_done[idx_q] = 1'b1;
            req_result      = res_q;
`ifdef INNER_ARB_TIMEOUT_EN
            if (err_q) begin
                req_err[idx_q] = 1'b1;
                unit_aclr      = 1'b1;
            end
`endif
        end
    end

endmodule
